// File: rtl/uart8250_bus_seq.sv
// uart8250_bus_seq: sequences single commands into strobed bus cycles for an
// 8250-style serial controller and returns one response per command.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   cmd_valid/ready/op/data   command handshake (op: 00 TX, 01 RX, 10 MCTRL, 11 STATUS)
//   rsp_valid/ready/data/err  response handshake
//   cs, wr, rd (active low)   chip select, control-write and status-read strobes
//   a0                        data/status address select
//   dis, dos (active high)    data-write and data-read strobes
//   bus_out                   data driven to the controller
//   bus_in, bus_en            data and valid qualifier returned by the controller
module uart8250_bus_seq #(
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned TXWAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       cs,
    output logic       wr,
    output logic       rd,
    output logic       a0,
    output logic       dis,
    output logic       dos,
    output logic [7:0] bus_out,
    input  logic [7:0] bus_in,
    input  logic       bus_en
);

    localparam logic [1:0] OpTx     = 2'b00;
    localparam logic [1:0] OpRx     = 2'b01;
    localparam logic [1:0] OpMctrl  = 2'b10;
    localparam logic [1:0] OpStatus = 2'b11;

    localparam logic [3:0] StrobeLast = 4'(STROBE_CYC - 1);
    localparam logic [7:0] TxWaitMax  = 8'(TXWAIT_MAX);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StEval, StResp} state_t;
    typedef enum logic [1:0] {PhStatus, PhCtrl, PhRead, PhWrite} phase_t;

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [1:0] op_q, op_d;
    logic [7:0] data_q, data_d;
    logic [3:0] strb_cnt_q, strb_cnt_d;
    logic [7:0] poll_q, poll_d;
    logic [7:0] samp_q, samp_d;
    logic       samp_en_q, samp_en_d;
    logic       a0_q, a0_d;
    logic [7:0] bus_out_q, bus_out_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;
    logic       ready_en_q;
    logic [7:0] poll_inc;
    logic       accept;
    logic       strobe;

    assign accept = cmd_valid & cmd_ready;
    // Saturating increment: the poll counter never wraps.
    assign poll_inc = (poll_q == 8'hFF) ? poll_q : poll_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        op_d        = op_q;
        data_d      = data_q;
        strb_cnt_d  = strb_cnt_q;
        poll_d      = poll_q;
        samp_d      = samp_q;
        samp_en_d   = samp_en_q;
        a0_d        = a0_q;
        bus_out_d   = bus_out_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d      = cmd_op;
                    data_d    = cmd_data;
                    poll_d    = 8'd0;
                    state_d   = StSetup;
                    a0_d      = 1'b0;
                    bus_out_d = 8'd0;
                    case (cmd_op)
                        OpTx:     phase_d = PhStatus;
                        OpRx:     phase_d = PhRead;
                        OpMctrl: begin
                            phase_d   = PhCtrl;
                            bus_out_d = cmd_data;
                        end
                        OpStatus: phase_d = PhStatus;
                        default:  phase_d = PhStatus;
                    endcase
                end
            end
            StSetup: begin
                strb_cnt_d = 4'd0;
                state_d    = StStrobe;
            end
            StStrobe: begin
                if (strb_cnt_q == StrobeLast) begin
                    // Only the last strobe cycle samples the returned bus.
                    samp_d    = bus_in;
                    samp_en_d = bus_en;
                    state_d   = StHold;
                end else begin
                    strb_cnt_d = strb_cnt_q + 4'd1;
                end
            end
            StHold: state_d = StEval;
            StEval: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                case (phase_q)
                    PhCtrl:  rsp_data_d = data_q;
                    PhWrite: rsp_data_d = data_q;
                    PhRead: begin
                        rsp_data_d = samp_q;
                        rsp_err_d  = ~samp_en_q;
                    end
                    default: begin
                        rsp_data_d = {4'b0, samp_q[3:0]};
                        if (op_q == OpTx) begin
                            poll_d = poll_inc;
                            if (samp_q[3]) begin
                                // CTS set: follow with the data-write phase.
                                state_d     = StSetup;
                                rsp_valid_d = 1'b0;
                                rsp_data_d  = rsp_data_q;
                                phase_d     = PhWrite;
                                a0_d        = 1'b1;
                                bus_out_d   = data_q;
                            end else if (poll_inc == TxWaitMax) begin
                                rsp_err_d = 1'b1;
                            end else begin
                                state_d     = StSetup;
                                rsp_valid_d = 1'b0;
                                rsp_data_d  = rsp_data_q;
                                a0_d        = 1'b0;
                                bus_out_d   = 8'd0;
                            end
                        end
                    end
                endcase
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= PhStatus;
            op_q        <= 2'b00;
            data_q      <= 8'd0;
            strb_cnt_q  <= 4'd0;
            poll_q      <= 8'd0;
            samp_q      <= 8'd0;
            samp_en_q   <= 1'b0;
            a0_q        <= 1'b0;
            bus_out_q   <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_err_q   <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            op_q        <= op_d;
            data_q      <= data_d;
            strb_cnt_q  <= strb_cnt_d;
            poll_q      <= poll_d;
            samp_q      <= samp_d;
            samp_en_q   <= samp_en_d;
            a0_q        <= a0_d;
            bus_out_q   <= bus_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            // Holds cmd_ready low until the first edge after reset release.
            ready_en_q  <= 1'b1;
        end
    end

    // Strobes decode straight from the state register so reset kills them at once.
    assign strobe    = (state_q == StStrobe);
    assign cs        = ~(strobe & ((phase_q == PhCtrl) | (phase_q == PhStatus)));
    assign wr        = ~(strobe & (phase_q == PhCtrl));
    assign rd        = ~(strobe & (phase_q == PhStatus));
    assign dis       = strobe & (phase_q == PhWrite);
    assign dos       = strobe & (phase_q == PhRead);
    assign a0        = a0_q;
    assign bus_out   = bus_out_q;
    assign cmd_ready = ready_en_q & (state_q == StIdle) & ~rsp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/uart8250_bus_seq.md
UART8250_BUS_SEQ -- requirements
Module: uart8250_bus_seq

Interface
REQ-001 SHALL have parameter STROBE_CYC, default 2, meaning strobe active width in clk cycles (legal 1..15).
REQ-002 SHALL have parameter TXWAIT_MAX, default 255, meaning the maximum number of CTS status polls before a transmit times out (legal 1..255).
REQ-003 SHALL use one clock and an asynchronous, active-high reset, declared as the first two ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous reset, active high.
REQ-004 SHALL have the following ports, in this order after clk and rst:
- cmd_valid  in  1  command request.
- cmd_ready  out 1  command accept.
- cmd_op  in  2  opcode: 00 TXDATA, 01 RXDATA, 10 MCTRL write, 11 STATUS read.
- cmd_data  in  8  write payload.
- rsp_valid  out 1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out 8  response payload.
- rsp_err  out 1  response error flag.
- cs  out 1  chip select, active low.
- wr  out 1  control-write strobe, active low.
- rd  out 1  status-read strobe, active low.
- a0  out 1  data/status address select.
- dis  out 1  data-write strobe, active high.
- dos  out 1  data-read strobe, active high.
- bus_out  out 8  data driven to the serial controller.
- bus_in  in  8  data returned from the serial controller.
- bus_en  in  1  bus_in valid qualifier.

Function
REQ-005 SHALL accept a command only on a cycle where cmd_valid=1 and cmd_ready=1, registering cmd_op and cmd_data at that edge.
REQ-006 SHALL drive cmd_ready=1 only in state IDLE with rsp_valid=0.
REQ-007 SHALL implement the FSM states IDLE, SETUP, STROBE, HOLD, EVAL and RESP.
REQ-008 SHALL follow these transitions:
- IDLE->SETUP on accept.
- SETUP->STROBE after 1 cycle.
- STROBE->HOLD after exactly STROBE_CYC cycles.
- HOLD->EVAL after 1 cycle.
- EVAL->RESP or EVAL->SETUP, per REQ-013 and REQ-014.
- RESP->IDLE when rsp_ready=1.
REQ-009 SHALL hold a0 and bus_out stable from SETUP through HOLD of each phase, and SHALL assert strobes only in STROBE.
REQ-010 SHALL never assert more than one of {wr low, rd low, dis, dos} in any cycle, and SHALL leave at least one SETUP cycle between consecutive strobes.
REQ-011 MCTRL SHALL run one phase with cs=0, wr=0 in STROBE and bus_out=cmd_data; its response is rsp_data=cmd_data, rsp_err=0.
REQ-012 STATUS SHALL run one phase with cs=0, rd=0 in STROBE, sampling bus_in on the last STROBE cycle; its response is rsp_data={4'b0, sampled[3:0]}, rsp_err=0.
REQ-013 RXDATA SHALL run one phase with a0=0, dos=1 in STROBE, sampling bus_in and bus_en on the last STROBE cycle; its response is rsp_data=sampled bus_in, rsp_err=~sampled bus_en.
REQ-014 TXDATA SHALL behave as follows:
- Start with a status poll phase (as in REQ-012) and increment the 8-bit poll counter in EVAL.
- If sampled bit3 (CTS)=1, run a data phase with a0=1, bus_out=cmd_data and dis=1 in STROBE, then respond rsp_data=cmd_data, rsp_err=0.
- Else, if the counter equals TXWAIT_MAX, respond rsp_data={4'b0, status[3:0]}, rsp_err=1.
- Else, return to SETUP for another poll.
- The counter SHALL clear on accept and SHALL not wrap.
REQ-015 SHALL register rsp_valid=1 on entry to RESP and hold rsp_data/rsp_err constant until the cycle rsp_valid=1 and rsp_ready=1, after which rsp_valid=0 on the next cycle.
REQ-016 Latency: for single-phase ops, rsp_valid SHALL rise STROBE_CYC+3 cycles after the accept edge; for TXDATA with CTS already set, it SHALL rise 2*(STROBE_CYC+3) cycles after the accept edge.
REQ-017 Outside STROBE: cs=1, wr=1, rd=1, dis=0, dos=0.
REQ-018 cmd_valid changes while busy SHALL have no effect.
REQ-019 bus_in and bus_en SHALL be ignored outside the sample cycle.

Reset
REQ-020 While rst=1 (asynchronously):
- State = IDLE; poll counter = 0.
- cs=1, wr=1, rd=1, a0=0, dis=0, dos=0.
- bus_out=0, rsp_valid=0, rsp_data=0, rsp_err=0, cmd_ready=0.
REQ-021 Reset asserted mid-strobe SHALL deassert the strobe immediately, without waiting for clk, and SHALL discard the command with no response.
REQ-022 cmd_ready SHALL rise on the first clk edge after rst deasserts.

Verification
REQ-023 MCTRL with cmd_data=8'hC0 -> wr low for exactly 2 cycles, bus_out=C0 throughout; rsp_valid at accept+5, rsp_data=C0, rsp_err=0.
REQ-024 STATUS with bus_in=8'hFA -> rd low for 2 cycles; rsp_data=8'h0A.
REQ-025 TXDATA 8'h55 with bus_in[3]=0 for 3 polls, then 1 -> 4 rd pulses, then 1 dis pulse with a0=1, bus_out=55; rsp_data=55, rsp_err=0.
REQ-026 TXDATA with TXWAIT_MAX=4 and bus_in[3] held 0 -> exactly 4 rd pulses, no dis pulse; rsp_err=1.
REQ-027 RXDATA with bus_in=8'h3C and bus_en=0 on the sample cycle -> rsp_data=3C, rsp_err=1; with rsp_ready held 0 for 5 cycles, rsp_valid stays 1 with data constant and cmd_ready=0.
REQ-028 rst pulsed during the second dis cycle -> dis=0 in the same cycle, no response, cmd_ready=1 after release.
